snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
- Game-state block directly upstream of the VGA controller.
- Holds the snake body as a ring buffer of grid cells plus a 64x48 occupancy bitmap, and advances the snake one cell per move tick.
- Detects food, wall and self collisions.
- Answers per-pixel colour queries: it takes the controller's oCoord_X/oCoord_Y and returns the pixel colour the controller drives on the VGA pins.

Parameters:
- GRID_W, 64, grid columns (640 px / CELL_PX)
- GRID_H, 48, grid rows (480 px / CELL_PX)
- CELL_PX, 10, pixels per cell side
- MAX_LEN, 256, ring buffer depth = maximum snake length
- INIT_LEN, 3, length after reset

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  synchronous active-high reset
- iTick  in  1  one-cycle move strobe (prescaled game rate)
- iDir  in  2  requested direction: 11 up, 00 down, 10 left, 01 right
- iFood_X  in  6  food column
- iFood_Y  in  6  food row
- iFood_Valid  in  1  food coordinates valid
- iCoord_X  in  10  active-area pixel X from VGA controller
- iCoord_Y  in  10  active-area pixel Y from VGA controller
- oRed  out  10  pixel red
- oGreen  out  10  pixel green
- oBlue  out  10  pixel blue
- oFood_Eaten  out  1  one-cycle pulse when the head lands on food
- oGame_Over  out  1  level, set on collision
- oLength  out  9  current snake length
- oBusy  out  1  engine not in RUN; ticks ignored

Behaviour:
- Interface: one clock, iCLK; reset iRST is synchronous and active-high. Both are fixed.
- Reset values: oFood_Eaten=0, oGame_Over=0, oLength=0, oBusy=1, colours=0, dir=01, state=CLEAR.
- Reset is honoured in any state, mid-move included: all registers are reset and the sweep restarts.
- CLEAR: sweeps the bitmap, clearing one bit per cycle over GRID_W*GRID_H = 3072 cycles. Then → SEED.
- SEED: pushes cells (30,24), (31,24), (32,24) in INIT_LEN cycles, setting bitmap bits. Tail ptr=0, head ptr=2, oLength=3. Then → RUN with oBusy=0.
- RUN: on iTick, samples iDir.
  - A 180° reversal of the current dir is ignored; the previous dir is kept.
  - Computes next head = head ±1 on one axis. → CALC.
  - iTick outside RUN is dropped.
- CALC: next head outside 0..GRID_W-1 or 0..GRID_H-1 (6-bit compare, underflow detected as 63 or ≥GRID_W/H) → DEAD. Else, reads the bitmap at the next head → CHECK.
- CHECK:
  - grow = iFood_Valid & next head == food & oLength < MAX_LEN.
  - Bit set at next head, and it is not the current tail cell with grow=0 → DEAD.
  - Moving into the tail cell while not growing is legal.
  - → TAIL if !grow, else → HEAD.
- TAIL: clears the bitmap bit at the tail cell; tail ptr +1 mod MAX_LEN. → HEAD.
- HEAD:
  - head ptr +1 mod MAX_LEN; writes the cell to the ring; sets the bitmap bit; oLength += grow.
  - oFood_Eaten pulses on a food hit, even when grow is suppressed by MAX_LEN.
  - → RUN.
  - A move takes 3 or 4 cycles after iTick.
- DEAD: oGame_Over=1, oBusy=1. Held until iRST.
- Render pipeline runs independently of the move state machine and has 2 cycles latency.
  - Stage 1: cx = iCoord_X/CELL_PX, cy = iCoord_Y/CELL_PX, registered.
  - Stage 2: reads bitmap port A; compares against the head and food registers; registers the colour.
- Render priority:
  - head: R=3FF, G=3FF, B=0.
  - body: 3FF/3FF/3FF, or 3FF/0/0 when oGame_Over.
  - food (iFood_Valid): 0/0/3FF.
  - otherwise 0.
  - During CLEAR/SEED the output is 0.
- The bitmap is true dual-port: port A is render read-only; port B is engine read/write. A same-cycle write and read of one cell returns the old value on port A.

Optional Feature:
- Macro SNAKE_WRAP_EN.
- Defined: an out-of-range next head wraps (−1 → GRID_W−1 / GRID_H−1, GRID_W → 0, GRID_H → 0). Walls never kill; the self-collision check is unchanged.
- Undefined: an out-of-range next head → DEAD.

Test Plan:
- iRST 1 cycle, run 3080 cycles → oBusy falls at cycle 3075, oLength=3. Pixel (325,245) after 2 cycles → 3FF/3FF/0 (head). Pixel (305,245) → white.
- iDir=01, iTick ×31 → head reaches (63,24). Next iTick → oGame_Over=1 within 2 cycles. With SNAKE_WRAP_EN instead: head (0,24), oGame_Over=0.
- Food (34,24) valid, iTick ×2 → one oFood_Eaten pulse on the 2nd move, oLength=4, tail unchanged on that move.
- While moving right, iDir=10 with iTick → moves right (reversal ignored).
- Length 5 snake loops into its own body: iDir sequence 00, 10, 11 → oGame_Over=1. Body pixels render 3FF/0/0.
- iRST asserted in CHECK state → oBusy=1, oLength=0 next cycle, CLEAR sweep restarts, no oFood_Eaten pulse.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: snake game state (ring buffer of cells + 64x48 occupancy bitmap) and per-pixel colour lookup.
// Latency: a move completes 3-4 cycles after iTick; pixel colour appears 2 cycles after iCoord_X/iCoord_Y.
// Backpressure: none; while oBusy is high iTick is dropped. Optional feature macro SNAKE_WRAP_EN (walls wrap).
module snake_engine #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int CELL_PX  = 10,
    parameter int MAX_LEN  = 256,
    parameter int INIT_LEN = 3
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iTick,
    input  logic [1:0] iDir,
    input  logic [5:0] iFood_X,
    input  logic [5:0] iFood_Y,
    input  logic       iFood_Valid,
    input  logic [9:0] iCoord_X,
    input  logic [9:0] iCoord_Y,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic       oFood_Eaten,
    output logic       oGame_Over,
    output logic [8:0] oLength,
    output logic       oBusy
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int AW    = $clog2(CELLS);
    localparam int PW    = $clog2(MAX_LEN);

    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(MAX_LEN - 1);
    localparam logic [PW-1:0] LAST_SEED = PW'(INIT_LEN - 1);
    localparam logic [8:0]    LEN_CAP   = 9'(MAX_LEN);
    localparam logic [6:0]    W7        = 7'(GRID_W);
    localparam logic [6:0]    H7        = 7'(GRID_H);
    localparam logic [5:0]    X_LAST    = 6'(GRID_W - 1);
    localparam logic [5:0]    Y_LAST    = 6'(GRID_H - 1);
    localparam logic [5:0]    SEED_X0   = 6'(GRID_W / 2 - INIT_LEN + 1);
    localparam logic [5:0]    SEED_Y    = 6'(GRID_H / 2);
    localparam logic [9:0]    CELL10    = 10'(CELL_PX);
    localparam logic [9:0]    W10       = 10'(GRID_W);
    localparam logic [9:0]    H10       = 10'(GRID_H);
    localparam logic [9:0]    FULL      = 10'h3FF;

    typedef enum logic [2:0] {
        S_CLEAR, S_SEED, S_RUN, S_CALC, S_CHECK, S_TAIL, S_HEAD, S_DEAD
    } state_t;

    // Row-major cell index into the occupancy bitmap.
    function automatic logic [AW-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
        return AW'(y) * AW'(GRID_W) + AW'(x);
    endfunction

    // Storage: bitmap (port A render read, port B engine read/write) and the body ring.
    logic          r_bitmap [CELLS];
    logic [5:0]    r_ring_x [MAX_LEN];
    logic [5:0]    r_ring_y [MAX_LEN];

    // Engine registers.
    state_t        r_state;
    logic [AW-1:0] r_clr_addr;
    logic [PW-1:0] r_seed_cnt;
    logic [PW-1:0] r_head_ptr;
    logic [PW-1:0] r_tail_ptr;
    logic [5:0]    r_head_x;
    logic [5:0]    r_head_y;
    logic [1:0]    r_dir;
    logic [6:0]    r_nx7;
    logic [6:0]    r_ny7;
    logic [5:0]    r_nx;
    logic [5:0]    r_ny;
    logic          r_rd_b;
    logic          r_grow;
    logic          r_food_hit;
    logic [8:0]    r_length;
    logic          r_food_eaten;

    // Render pipeline registers.
    logic [9:0]    r_cx;
    logic [9:0]    r_cy;
    logic [9:0]    r_red;
    logic [9:0]    r_green;
    logic [9:0]    r_blue;

    // Combinational nets.
    state_t        w_state_next;
    logic [1:0]    w_dir_eff;
    logic [6:0]    w_step_x;
    logic [6:0]    w_step_y;
    logic [5:0]    w_wx;
    logic [5:0]    w_wy;
    logic [5:0]    w_seed_x;
    logic [5:0]    w_tail_x;
    logic [5:0]    w_tail_y;
    logic          w_food_hit;
    logic          w_grow;
    logic          w_hit_tail;
    logic          w_self_hit;
    logic [PW-1:0] w_head_ptr_inc;
    logic [PW-1:0] w_tail_ptr_inc;
    logic          w_b_we;
    logic [AW-1:0] w_b_addr;
    logic          w_b_wdat;
    logic          w_ring_we;
    logic [PW-1:0] w_ring_addr;
    logic [5:0]    w_ring_x;
    logic [5:0]    w_ring_y;
    logic          w_in_grid;
    logic [AW-1:0] w_pix_addr;
    logic          w_pix_body;
    logic          w_pix_head;
    logic          w_pix_food;
    logic          w_render_en;
    logic [9:0]    w_r;
    logic [9:0]    w_g;
    logic [9:0]    w_b;

    assign w_seed_x       = SEED_X0 + 6'(r_seed_cnt);
    assign w_tail_x       = r_ring_x[r_tail_ptr];
    assign w_tail_y       = r_ring_y[r_tail_ptr];
    assign w_head_ptr_inc = (r_head_ptr == LAST_PTR) ? '0 : r_head_ptr + PW'(1);
    assign w_tail_ptr_inc = (r_tail_ptr == LAST_PTR) ? '0 : r_tail_ptr + PW'(1);

    // A 180-degree request is the bitwise inverse of the current direction; keep the old one then.
    always_comb begin
        w_dir_eff = (iDir == ~r_dir) ? r_dir : iDir;
        w_step_x  = {1'b0, r_head_x};
        w_step_y  = {1'b0, r_head_y};
        case (w_dir_eff)
            2'b11:   w_step_y = {1'b0, r_head_y} - 7'd1;
            2'b00:   w_step_y = {1'b0, r_head_y} + 7'd1;
            2'b10:   w_step_x = {1'b0, r_head_x} - 7'd1;
            default: w_step_x = {1'b0, r_head_x} + 7'd1;
        endcase
    end

    // Fold the 7-bit next head back into the grid; -1 shows up as 7'h7F.
    always_comb begin
        w_wx = r_nx7[5:0];
        w_wy = r_ny7[5:0];
        if (r_nx7 == 7'h7F)   w_wx = X_LAST;
        else if (r_nx7 >= W7) w_wx = 6'd0;
        if (r_ny7 == 7'h7F)   w_wy = Y_LAST;
        else if (r_ny7 >= H7) w_wy = 6'd0;
    end

`ifndef SNAKE_WRAP_EN
    logic w_oob;
    assign w_oob = (r_nx7 >= W7) || (r_ny7 >= H7);
`endif

    // Collision decision made in CHECK with the bitmap bit fetched during CALC.
    always_comb begin
        w_food_hit = iFood_Valid && (r_nx == iFood_X) && (r_ny == iFood_Y);
        w_grow     = w_food_hit && (r_length < LEN_CAP);
        w_hit_tail = (r_nx == w_tail_x) && (r_ny == w_tail_y);
        w_self_hit = r_rd_b && !(w_hit_tail && !w_grow);
    end

    // Next-state logic plus the bitmap port B and ring write controls.
    always_comb begin
        w_state_next = r_state;
        w_b_we       = 1'b0;
        w_b_addr     = r_clr_addr;
        w_b_wdat     = 1'b0;
        w_ring_we    = 1'b0;
        w_ring_addr  = r_seed_cnt;
        w_ring_x     = w_seed_x;
        w_ring_y     = SEED_Y;
        case (r_state)
            S_CLEAR: begin
                w_b_we = 1'b1;
                if (r_clr_addr == LAST_CELL) w_state_next = S_SEED;
            end
            S_SEED: begin
                w_b_we    = 1'b1;
                w_b_addr  = cell_addr(w_seed_x, SEED_Y);
                w_b_wdat  = 1'b1;
                w_ring_we = 1'b1;
                if (r_seed_cnt == LAST_SEED) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (iTick) w_state_next = S_CALC;
            end
            S_CALC: begin
                w_b_addr = cell_addr(w_wx, w_wy);
`ifdef SNAKE_WRAP_EN
                w_state_next = S_CHECK;
`else
                w_state_next = w_oob ? S_DEAD : S_CHECK;
`endif
            end
            S_CHECK: begin
                if (w_self_hit)  w_state_next = S_DEAD;
                else if (w_grow) w_state_next = S_HEAD;
                else             w_state_next = S_TAIL;
            end
            S_TAIL: begin
                w_b_we       = 1'b1;
                w_b_addr     = cell_addr(w_tail_x, w_tail_y);
                w_state_next = S_HEAD;
            end
            S_HEAD: begin
                w_b_we       = 1'b1;
                w_b_addr     = cell_addr(r_nx, r_ny);
                w_b_wdat     = 1'b1;
                w_ring_we    = 1'b1;
                w_ring_addr  = w_head_ptr_inc;
                w_ring_x     = r_nx;
                w_ring_y     = r_ny;
                w_state_next = S_RUN;
            end
            S_DEAD:  w_state_next = S_DEAD;
            default: w_state_next = S_CLEAR;
        endcase
    end

    // Bitmap port B write; contents are not reset, the CLEAR sweep zeroes them.
    always_ff @(posedge iCLK) begin
        if (!iRST && w_b_we) r_bitmap[w_b_addr] <= w_b_wdat;
    end

    // Body ring write: seed cells, then one new head per move.
    always_ff @(posedge iCLK) begin
        if (!iRST && w_ring_we) begin
            r_ring_x[w_ring_addr] <= w_ring_x;
            r_ring_y[w_ring_addr] <= w_ring_y;
        end
    end

    // Move state machine registers and datapath.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state      <= S_CLEAR;
            r_clr_addr   <= '0;
            r_seed_cnt   <= '0;
            r_head_ptr   <= '0;
            r_tail_ptr   <= '0;
            r_head_x     <= '0;
            r_head_y     <= '0;
            r_dir        <= 2'b01;
            r_nx7        <= '0;
            r_ny7        <= '0;
            r_nx         <= '0;
            r_ny         <= '0;
            r_rd_b       <= 1'b0;
            r_grow       <= 1'b0;
            r_food_hit   <= 1'b0;
            r_length     <= '0;
            r_food_eaten <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_food_eaten <= 1'b0;
            case (r_state)
                S_CLEAR: r_clr_addr <= r_clr_addr + AW'(1);
                S_SEED: begin
                    r_seed_cnt <= r_seed_cnt + PW'(1);
                    r_head_ptr <= r_seed_cnt;
                    r_head_x   <= w_seed_x;
                    r_head_y   <= SEED_Y;
                    r_length   <= r_length + 9'd1;
                end
                S_RUN: begin
                    if (iTick) begin
                        r_dir <= w_dir_eff;
                        r_nx7 <= w_step_x;
                        r_ny7 <= w_step_y;
                    end
                end
                S_CALC: begin
                    r_nx   <= w_wx;
                    r_ny   <= w_wy;
                    r_rd_b <= r_bitmap[w_b_addr];
                end
                S_CHECK: begin
                    r_grow     <= w_grow;
                    r_food_hit <= w_food_hit;
                end
                S_TAIL: r_tail_ptr <= w_tail_ptr_inc;
                S_HEAD: begin
                    r_head_ptr   <= w_head_ptr_inc;
                    r_head_x     <= r_nx;
                    r_head_y     <= r_ny;
                    r_length     <= r_length + {8'd0, r_grow};
                    r_food_eaten <= r_food_hit;
                end
                default: ;
            endcase
        end
    end

    // Render stage 2 lookup: bitmap port A plus head/food compares; head wins over body over food.
    always_comb begin
        w_in_grid   = (r_cx < W10) && (r_cy < H10);
        w_pix_addr  = cell_addr(r_cx[5:0], r_cy[5:0]);
        w_pix_body  = w_in_grid && r_bitmap[w_pix_addr];
        w_pix_head  = (r_cx == {4'd0, r_head_x}) && (r_cy == {4'd0, r_head_y});
        w_pix_food  = iFood_Valid && (r_cx == {4'd0, iFood_X}) && (r_cy == {4'd0, iFood_Y});
        w_render_en = (r_state != S_CLEAR) && (r_state != S_SEED);
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_render_en) begin
            if (w_pix_head) begin
                w_r = FULL;
                w_g = FULL;
            end else if (w_pix_body) begin
                w_r = FULL;
                if (!oGame_Over) begin
                    w_g = FULL;
                    w_b = FULL;
                end
            end else if (w_pix_food) begin
                w_b = FULL;
            end
        end
    end

    // Render pipeline: stage 1 registers the cell coordinates, stage 2 registers the colour.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cx    <= '0;
            r_cy    <= '0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_cx    <= iCoord_X / CELL10;
            r_cy    <= iCoord_Y / CELL10;
            r_red   <= w_r;
            r_green <= w_g;
            r_blue  <= w_b;
        end
    end

    assign oRed        = r_red;
    assign oGreen      = r_green;
    assign oBlue       = r_blue;
    assign oFood_Eaten = r_food_eaten;
    assign oGame_Over  = (r_state == S_DEAD);
    assign oLength     = r_length;
    assign oBusy       = (r_state != S_RUN);

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed scenarios for snake_engine with hand-computed expectations.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_snake_engine;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic       iTick = 1'b0;
    logic [1:0] iDir = 2'b01;
    logic [5:0] iFood_X = 6'd0;
    logic [5:0] iFood_Y = 6'd0;
    logic       iFood_Valid = 1'b0;
    logic [9:0] iCoord_X = 10'd0;
    logic [9:0] iCoord_Y = 10'd0;
    logic [9:0] oRed;
    logic [9:0] oGreen;
    logic [9:0] oBlue;
    logic       oFood_Eaten;
    logic       oGame_Over;
    logic [8:0] oLength;
    logic       oBusy;

    int total = 0;
    int bad   = 0;

    localparam logic [29:0] C_BLACK  = {10'h000, 10'h000, 10'h000};
    localparam logic [29:0] C_HEAD   = {10'h3FF, 10'h3FF, 10'h000};
    localparam logic [29:0] C_BODY   = {10'h3FF, 10'h3FF, 10'h3FF};
    localparam logic [29:0] C_DEAD   = {10'h3FF, 10'h000, 10'h000};
    localparam logic [29:0] C_FOOD   = {10'h000, 10'h000, 10'h3FF};

    snake_engine dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iTick       (iTick),
        .iDir        (iDir),
        .iFood_X     (iFood_X),
        .iFood_Y     (iFood_Y),
        .iFood_Valid (iFood_Valid),
        .iCoord_X    (iCoord_X),
        .iCoord_Y    (iCoord_Y),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue),
        .oFood_Eaten (oFood_Eaten),
        .oGame_Over  (oGame_Over),
        .oLength     (oLength),
        .oBusy       (oBusy)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drive a pixel coordinate and wait out the two-stage render pipeline.
    task automatic set_pixel(input int x, input int y);
        @(negedge iCLK);
        iCoord_X = 10'(x);
        iCoord_Y = 10'(y);
        @(negedge iCLK);
        @(negedge iCLK);
    endtask

    // Pulse reset for one edge and wait (bounded) until the engine reaches RUN.
    task automatic reset_engine(output int cycles);
        @(negedge iCLK);
        iRST  = 1'b1;
        iTick = 1'b0;
        @(negedge iCLK);
        iRST = 1'b0;
        cycles = 0;
        while (oBusy === 1'b1 && cycles < 4000) begin
            @(negedge iCLK);
            cycles++;
        end
    endtask

    // One tick in direction d; counts food pulses and cycles until RUN or death.
    task automatic move(input logic [1:0] d, output int pulses, output int n);
        pulses = 0;
        @(negedge iCLK);
        iDir  = d;
        iTick = 1'b1;
        @(negedge iCLK);
        iTick = 1'b0;
        n = 0;
        while (oBusy === 1'b1 && oGame_Over !== 1'b1 && n < 10) begin
            if (oFood_Eaten === 1'b1) pulses++;
            @(negedge iCLK);
            n++;
        end
        if (oFood_Eaten === 1'b1) pulses++;
        total++;
        if (n >= 10) begin
            bad++;
            $display("FAIL move_timeout cycles=%0d limit=10", n);
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", oBusy); end
        total++; if (oLength !== 9'd0) begin bad++; $display("FAIL rst_length got=%0d exp=0", oLength); end
        total++; if (oGame_Over !== 1'b0) begin bad++; $display("FAIL rst_gameover got=%b exp=0", oGame_Over); end
        total++; if (oFood_Eaten !== 1'b0) begin bad++; $display("FAIL rst_food_eaten got=%b exp=0", oFood_Eaten); end
        total++; if ({oRed, oGreen, oBlue} !== C_BLACK) begin bad++; $display("FAIL rst_colour got=%h exp=%h", {oRed, oGreen, oBlue}, C_BLACK); end
        iRST = 1'b0;
        n = 0;
        while (oBusy === 1'b1 && n < 4000) begin
            @(negedge iCLK);
            n++;
        end
        total++; if (n != 3075) begin bad++; $display("FAIL init_cycles got=%0d exp=3075", n); end
        total++; if (oLength !== 9'd3) begin bad++; $display("FAIL init_length got=%0d exp=3", oLength); end
    endtask

    task automatic test_render();
        iFood_X = 6'd34;
        iFood_Y = 6'd24;
        iFood_Valid = 1'b1;
        @(negedge iCLK);
        iCoord_X = 10'd325;
        iCoord_Y = 10'd245;
        @(negedge iCLK);
        total++; if ({oRed, oGreen, oBlue} !== C_BLACK) begin bad++; $display("FAIL render_latency1 got=%h exp=%h", {oRed, oGreen, oBlue}, C_BLACK); end
        @(negedge iCLK);
        total++; if ({oRed, oGreen, oBlue} !== C_HEAD) begin bad++; $display("FAIL render_head got=%h exp=%h", {oRed, oGreen, oBlue}, C_HEAD); end
        set_pixel(305, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_BODY) begin bad++; $display("FAIL render_body got=%h exp=%h", {oRed, oGreen, oBlue}, C_BODY); end
        set_pixel(335, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_BLACK) begin bad++; $display("FAIL render_empty got=%h exp=%h", {oRed, oGreen, oBlue}, C_BLACK); end
        set_pixel(345, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_FOOD) begin bad++; $display("FAIL render_food got=%h exp=%h", {oRed, oGreen, oBlue}, C_FOOD); end
    endtask

    task automatic test_food();
        int p, n;
        move(2'b01, p, n);
        total++; if (p != 0) begin bad++; $display("FAIL food_move1_pulse got=%0d exp=0", p); end
        total++; if (oLength !== 9'd3) begin bad++; $display("FAIL food_move1_len got=%0d exp=3", oLength); end
        set_pixel(305, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_BLACK) begin bad++; $display("FAIL food_tail_freed got=%h exp=%h", {oRed, oGreen, oBlue}, C_BLACK); end
        move(2'b01, p, n);
        total++; if (p != 1) begin bad++; $display("FAIL food_move2_pulse got=%0d exp=1", p); end
        total++; if (oLength !== 9'd4) begin bad++; $display("FAIL food_move2_len got=%0d exp=4", oLength); end
        set_pixel(315, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_BODY) begin bad++; $display("FAIL food_tail_kept got=%h exp=%h", {oRed, oGreen, oBlue}, C_BODY); end
        set_pixel(345, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_HEAD) begin bad++; $display("FAIL food_head_priority got=%h exp=%h", {oRed, oGreen, oBlue}, C_HEAD); end
        iFood_Valid = 1'b0;
    endtask

    task automatic test_reversal();
        int p, n;
        move(2'b10, p, n);
        set_pixel(355, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_HEAD) begin bad++; $display("FAIL reversal_head got=%h exp=%h", {oRed, oGreen, oBlue}, C_HEAD); end
        set_pixel(345, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_BODY) begin bad++; $display("FAIL reversal_body got=%h exp=%h", {oRed, oGreen, oBlue}, C_BODY); end
        total++; if (oLength !== 9'd4) begin bad++; $display("FAIL reversal_len got=%0d exp=4", oLength); end
    endtask

    task automatic test_wall();
        int p, n;
        for (int i = 0; i < 28; i++) move(2'b01, p, n);
        set_pixel(635, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_HEAD) begin bad++; $display("FAIL wall_head63 got=%h exp=%h", {oRed, oGreen, oBlue}, C_HEAD); end
        total++; if (oGame_Over !== 1'b0) begin bad++; $display("FAIL wall_alive got=%b exp=0", oGame_Over); end
        move(2'b01, p, n);
`ifdef SNAKE_WRAP_EN
        total++; if (oGame_Over !== 1'b0) begin bad++; $display("FAIL wrap_alive got=%b exp=0", oGame_Over); end
        set_pixel(5, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_HEAD) begin bad++; $display("FAIL wrap_head0 got=%h exp=%h", {oRed, oGreen, oBlue}, C_HEAD); end
        set_pixel(635, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_BODY) begin bad++; $display("FAIL wrap_body63 got=%h exp=%h", {oRed, oGreen, oBlue}, C_BODY); end
`else
        total++; if (oGame_Over !== 1'b1) begin bad++; $display("FAIL wall_dead got=%b exp=1", oGame_Over); end
        total++; if (n != 1) begin bad++; $display("FAIL wall_dead_latency got=%0d exp=1", n); end
        total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL wall_busy got=%b exp=1", oBusy); end
        set_pixel(625, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_DEAD) begin bad++; $display("FAIL wall_body_red got=%h exp=%h", {oRed, oGreen, oBlue}, C_DEAD); end
        @(negedge iCLK);
        iTick = 1'b1;
        @(negedge iCLK);
        iTick = 1'b0;
        repeat (5) @(negedge iCLK);
        total++; if (oGame_Over !== 1'b1 || oLength !== 9'd4) begin bad++; $display("FAIL dead_hold got=%b/%0d exp=1/4", oGame_Over, oLength); end
`endif
    endtask

    task automatic test_tail_follow();
        int c, p, n;
        reset_engine(c);
        total++; if (c != 3075) begin bad++; $display("FAIL tail_reset_cycles got=%0d exp=3075", c); end
        iFood_X = 6'd33;
        iFood_Y = 6'd24;
        iFood_Valid = 1'b1;
        move(2'b01, p, n);
        total++; if (p != 1 || oLength !== 9'd4) begin bad++; $display("FAIL tail_grow got=%0d/%0d exp=1/4", p, oLength); end
        iFood_Valid = 1'b0;
        move(2'b00, p, n);
        move(2'b10, p, n);
        move(2'b11, p, n);
        total++; if (oGame_Over !== 1'b0) begin bad++; $display("FAIL tail_follow_alive got=%b exp=0", oGame_Over); end
        total++; if (oLength !== 9'd4) begin bad++; $display("FAIL tail_follow_len got=%0d exp=4", oLength); end
        set_pixel(325, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_HEAD) begin bad++; $display("FAIL tail_follow_head got=%h exp=%h", {oRed, oGreen, oBlue}, C_HEAD); end
        set_pixel(325, 255);
        total++; if ({oRed, oGreen, oBlue} !== C_BODY) begin bad++; $display("FAIL tail_follow_body got=%h exp=%h", {oRed, oGreen, oBlue}, C_BODY); end
    endtask

    task automatic test_self_collision();
        int c, p, n;
        reset_engine(c);
        total++; if (c != 3075) begin bad++; $display("FAIL self_reset_cycles got=%0d exp=3075", c); end
        iFood_X = 6'd33;
        iFood_Y = 6'd24;
        iFood_Valid = 1'b1;
        move(2'b01, p, n);
        iFood_X = 6'd34;
        move(2'b01, p, n);
        iFood_Valid = 1'b0;
        total++; if (oLength !== 9'd5) begin bad++; $display("FAIL self_len got=%0d exp=5", oLength); end
        move(2'b00, p, n);
        move(2'b10, p, n);
        total++; if (oGame_Over !== 1'b0) begin bad++; $display("FAIL self_alive got=%b exp=0", oGame_Over); end
        move(2'b11, p, n);
        total++; if (oGame_Over !== 1'b1) begin bad++; $display("FAIL self_dead got=%b exp=1", oGame_Over); end
        set_pixel(345, 245);
        total++; if ({oRed, oGreen, oBlue} !== C_DEAD) begin bad++; $display("FAIL self_body_red got=%h exp=%h", {oRed, oGreen, oBlue}, C_DEAD); end
        set_pixel(335, 255);
        total++; if ({oRed, oGreen, oBlue} !== C_HEAD) begin bad++; $display("FAIL self_head got=%h exp=%h", {oRed, oGreen, oBlue}, C_HEAD); end
    endtask

    task automatic test_reset_mid_move();
        int c, n, pulses;
        reset_engine(c);
        iFood_X = 6'd33;
        iFood_Y = 6'd24;
        iFood_Valid = 1'b1;
        @(negedge iCLK);
        iDir  = 2'b01;
        iTick = 1'b1;
        @(negedge iCLK);
        iTick = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL mid_rst_busy got=%b exp=1", oBusy); end
        total++; if (oLength !== 9'd0) begin bad++; $display("FAIL mid_rst_length got=%0d exp=0", oLength); end
        total++; if (oGame_Over !== 1'b0) begin bad++; $display("FAIL mid_rst_gameover got=%b exp=0", oGame_Over); end
        iRST = 1'b0;
        iCoord_X = 10'd325;
        iCoord_Y = 10'd245;
        pulses = 0;
        if (oFood_Eaten === 1'b1) pulses++;
        n = 0;
        while (oBusy === 1'b1 && n < 4000) begin
            @(negedge iCLK);
            n++;
            if (oFood_Eaten === 1'b1) pulses++;
            if (n == 5) begin
                total++; if ({oRed, oGreen, oBlue} !== C_BLACK) begin bad++; $display("FAIL mid_rst_clear_colour got=%h exp=%h", {oRed, oGreen, oBlue}, C_BLACK); end
            end
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL mid_rst_no_pulse got=%0d exp=0", pulses); end
        total++; if (n != 3075) begin bad++; $display("FAIL mid_rst_sweep got=%0d exp=3075", n); end
        total++; if (oLength !== 9'd3) begin bad++; $display("FAIL mid_rst_relen got=%0d exp=3", oLength); end
    endtask

    initial begin
        test_reset();
        test_render();
        test_food();
        test_reversal();
        test_wall();
        test_tail_follow();
        test_self_collision();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
